orv64_pmp_csr_file: RTL and testbench

Machine-mode register file holding the 16 PMP entries (pmpcfg0/pmpcfg2, pmpaddr0–15) for the ORV64 core. It accepts CSR read/write/set/clear requests from the CSR unit over a valid/ready request and response handshake. It applies the lock and WARL rules, and drives the configuration that the PMP checker consumes. It also signals configuration changes, so the TLB and fetch path can flush stale permission results.

---
 rtl/orv64_pmp_csr_file_pkg.sv | 36 +++
 rtl/orv64_pmp_cfg_byte_wr.sv | 20 ++
 rtl/orv64_pmp_csr_file.sv | 162 ++++++++++++++++
 tb/tb_orv64_pmp_csr_file.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/orv64_pmp_csr_file_pkg.sv
// Shared ORV64 PMP definitions: CSR addresses, pmpcfg byte layout, CSR op and FSM encodings.
package orv64_pmp_csr_file_pkg;

   localparam logic [11:0] ORV64_CSR_ADDR_PMPCFG0  = 12'h3A0;
   localparam logic [11:0] ORV64_CSR_ADDR_PMPCFG2  = 12'h3A2;
   localparam logic [11:0] ORV64_CSR_ADDR_PMPADDR0 = 12'h3B0;

   typedef enum logic [1:0] {
      PMP_A_OFF   = 2'd0,
      PMP_A_TOR   = 2'd1,
      PMP_A_NA4   = 2'd2,
      PMP_A_NAPOT = 2'd3
   } pmp_a_e;

   typedef struct packed {
      logic       l;
      logic [1:0] rsvd;
      pmp_a_e     a;
      logic       x;
      logic       w;
      logic       r;
   } pmpcfg_t;

   typedef enum logic [1:0] {
      CSR_OP_READ  = 2'd0,
      CSR_OP_WRITE = 2'd1,
      CSR_OP_SET   = 2'd2,
      CSR_OP_CLEAR = 2'd3
   } csr_op_e;

   typedef enum logic {
      CSR_ST_IDLE = 1'b0,
      CSR_ST_RESP = 1'b1
   } csr_state_e;

endpackage

// File: rtl/orv64_pmp_cfg_byte_wr.sv
// Next-value logic for one pmpcfg byte: lock hold, WARL reject of r=0/w=1, reserved bits cleared.
module orv64_pmp_cfg_byte_wr
   import orv64_pmp_csr_file_pkg::*;
(
   input  pmpcfg_t    old_byte,
   input  logic [7:0] new_byte,
   input  logic       locked,
   output pmpcfg_t    next_byte
);

   pmpcfg_t cand;

   always_comb begin
      cand      = pmpcfg_t'(new_byte);
      cand.rsvd = 2'b00;
      next_byte = cand;
      if (locked || (!cand.r && cand.w)) next_byte = old_byte;
   end

endmodule

// File: rtl/orv64_pmp_csr_file.sv
// Machine-mode PMP CSR file (pmpcfg/pmpaddr) with valid/ready request and response channels.
// Optional macro ORV64_PMP_TOR_LOCK_EN: a locked TOR entry i+1 also locks pmpaddr i.
module orv64_pmp_csr_file
   import orv64_pmp_csr_file_pkg::*;
#(
   parameter int N_ENTRY = 16,
   parameter int PADDR_W = 56
) (
   input  logic                           clk,
   input  logic                           rstn,
   // Handshakes: a beat transfers on the rising edge where valid and ready are both high;
   // valid must stay asserted with stable payload until that edge.
   input  logic                           csr_req_valid,
   output logic                           csr_req_ready,
   input  logic [1:0]                     csr_req_op,
   input  logic [11:0]                    csr_req_addr,
   input  logic [63:0]                    csr_req_wdata,
   output logic                           csr_resp_valid,
   input  logic                           csr_resp_ready,
   output logic [63:0]                    csr_resp_rdata,
   output logic                           csr_resp_illegal,
   output logic [N_ENTRY*8-1:0]           pmpcfg,
   output logic [N_ENTRY*(PADDR_W-2)-1:0] pmpaddr,
   output logic                           pmp_chg_valid,
   output csr_state_e                     csr_state
);

   localparam int AW    = PADDR_W - 2;
   localparam int N_GRP = N_ENTRY / 8;
   localparam logic [11:0] CFG_STRIDE = ORV64_CSR_ADDR_PMPCFG2 - ORV64_CSR_ADDR_PMPCFG0;

   csr_state_e        state_q, state_d;
   pmpcfg_t           cfg_q  [N_ENTRY];
   pmpcfg_t           cfg_d  [N_ENTRY];
   pmpcfg_t           cfg_wr [N_ENTRY];
   logic [AW-1:0]     addr_q [N_ENTRY];
   logic [AW-1:0]     addr_d [N_ENTRY];
   logic [N_ENTRY-1:0] addr_locked, addr_sel;
   logic [N_GRP-1:0]  grp_sel;
   logic [63:0]       old_val, new_val, rdata_q;
   logic              req_accept, req_illegal, do_write, any_chg, chg_q, illegal_q;
   csr_op_e           op;

   assign op         = csr_op_e'(csr_req_op);
   assign req_accept = csr_req_valid && (state_q == CSR_ST_IDLE);
   assign do_write   = req_accept && !req_illegal && (op != CSR_OP_READ);

   always_comb begin
      old_val     = '0;
      req_illegal = 1'b1;
      grp_sel     = '0;
      addr_sel    = '0;
      for (int k = 0; k < N_GRP; k++) begin
         if (csr_req_addr == ORV64_CSR_ADDR_PMPCFG0 + 12'(k) * CFG_STRIDE) begin
            grp_sel[k]  = 1'b1;
            req_illegal = 1'b0;
            for (int j = 0; j < 8; j++) old_val[j*8 +: 8] = cfg_q[k*8 + j];
         end
      end
      for (int i = 0; i < N_ENTRY; i++) begin
         if (csr_req_addr == ORV64_CSR_ADDR_PMPADDR0 + 12'(i)) begin
            addr_sel[i]      = 1'b1;
            req_illegal      = 1'b0;
            old_val[AW-1:0]  = addr_q[i];
         end
      end
   end

   always_comb begin
      case (op)
         CSR_OP_WRITE: new_val = csr_req_wdata;
         CSR_OP_SET:   new_val = old_val | csr_req_wdata;
         CSR_OP_CLEAR: new_val = old_val & ~csr_req_wdata;
         default:      new_val = old_val;
      endcase
   end

   for (genvar i = 0; i < N_ENTRY; i++) begin : g_entry
      orv64_pmp_cfg_byte_wr u_cfg_wr (
         .old_byte  (cfg_q[i]),
         .new_byte  (new_val[(i%8)*8 +: 8]),
         .locked    (cfg_q[i].l),
         .next_byte (cfg_wr[i])
      );
`ifdef ORV64_PMP_TOR_LOCK_EN
      if (i < N_ENTRY - 1) begin : g_tor
         assign addr_locked[i] = cfg_q[i].l || (cfg_q[i+1].l && (cfg_q[i+1].a == PMP_A_TOR));
      end else begin : g_last
         assign addr_locked[i] = cfg_q[i].l;
      end
`else
      assign addr_locked[i] = cfg_q[i].l;
`endif
      assign pmpcfg[i*8 +: 8]    = cfg_q[i];
      assign pmpaddr[i*AW +: AW] = addr_q[i];
   end

   // Lock decisions read the pre-update cfg, so a same-request lock never blocks its own write.
   always_comb begin
      cfg_d   = cfg_q;
      addr_d  = addr_q;
      any_chg = 1'b0;
      if (do_write) begin
         for (int k = 0; k < N_GRP; k++)
            if (grp_sel[k])
               for (int j = 0; j < 8; j++) cfg_d[k*8 + j] = cfg_wr[k*8 + j];
         for (int i = 0; i < N_ENTRY; i++)
            if (addr_sel[i] && !addr_locked[i]) addr_d[i] = new_val[AW-1:0];
      end
      for (int i = 0; i < N_ENTRY; i++)
         if ((cfg_d[i] != cfg_q[i]) || (addr_d[i] != addr_q[i])) any_chg = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N_ENTRY; i++) begin
            cfg_q[i]  <= '0;
            addr_q[i] <= '0;
         end
         chg_q <= 1'b0;
      end else begin
         cfg_q  <= cfg_d;
         addr_q <= addr_d;
         chg_q  <= any_chg;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata_q   <= '0;
         illegal_q <= 1'b0;
      end else if (req_accept) begin
         rdata_q   <= old_val;
         illegal_q <= req_illegal;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= CSR_ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CSR_ST_IDLE: if (csr_req_valid)  state_d = CSR_ST_RESP;
         CSR_ST_RESP: if (csr_resp_ready) state_d = CSR_ST_IDLE;
         default:                         state_d = CSR_ST_IDLE;
      endcase
   end

   always_comb begin
      csr_req_ready  = (state_q == CSR_ST_IDLE);
      csr_resp_valid = (state_q == CSR_ST_RESP);
   end

   assign csr_resp_rdata   = rdata_q;
   assign csr_resp_illegal = illegal_q;
   assign pmp_chg_valid    = chg_q;
   assign csr_state        = state_q;

endmodule

// File: tb/tb_orv64_pmp_csr_file.sv
// Directed bench for orv64_pmp_csr_file: vector table plus backpressure and reset sequences.
module tb_orv64_pmp_csr_file;
   import orv64_pmp_csr_file_pkg::*;

   localparam int N_ENTRY = 16;
   localparam int PADDR_W = 56;
   localparam int AW      = PADDR_W - 2;
`ifdef ORV64_PMP_TOR_LOCK_EN
   localparam bit TOR_LOCK = 1'b1;
`else
   localparam bit TOR_LOCK = 1'b0;
`endif

   logic                      clk, rstn;
   logic                      csr_req_valid, csr_req_ready;
   logic [1:0]                csr_req_op;
   logic [11:0]               csr_req_addr;
   logic [63:0]               csr_req_wdata;
   logic                      csr_resp_valid, csr_resp_ready;
   logic [63:0]               csr_resp_rdata;
   logic                      csr_resp_illegal;
   logic [N_ENTRY*8-1:0]      pmpcfg;
   logic [N_ENTRY*AW-1:0]     pmpaddr;
   logic                      pmp_chg_valid;
   csr_state_e                csr_state;

   orv64_pmp_csr_file #(.N_ENTRY(N_ENTRY), .PADDR_W(PADDR_W)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .csr_req_valid    (csr_req_valid),
      .csr_req_ready    (csr_req_ready),
      .csr_req_op       (csr_req_op),
      .csr_req_addr     (csr_req_addr),
      .csr_req_wdata    (csr_req_wdata),
      .csr_resp_valid   (csr_resp_valid),
      .csr_resp_ready   (csr_resp_ready),
      .csr_resp_rdata   (csr_resp_rdata),
      .csr_resp_illegal (csr_resp_illegal),
      .pmpcfg           (pmpcfg),
      .pmpaddr          (pmpaddr),
      .pmp_chg_valid    (pmp_chg_valid),
      .csr_state        (csr_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic        ill;
      logic        chg;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"},  csr_req_ready,    64'd1);
      check({tag, "_resp_valid"}, csr_resp_valid,   64'd0);
      check({tag, "_rdata"},      csr_resp_rdata,   64'd0);
      check({tag, "_illegal"},    csr_resp_illegal, 64'd0);
      check({tag, "_chg"},        pmp_chg_valid,    64'd0);
      check({tag, "_pmpcfg_or"},  |pmpcfg,          64'd0);
      check({tag, "_pmpaddr_or"}, |pmpaddr,         64'd0);
   endtask

   // driver: one request with csr_resp_ready high; returns response and change pulse
   task automatic do_req(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wdata,
                         input string tag, output logic [63:0] rdata, output logic ill,
                         output logic chg);
      int waited = 0;
      @(negedge clk);
      while (!csr_req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_req_ready"}, csr_req_ready, 64'd1);
      csr_req_valid = 1'b1;
      csr_req_op    = op;
      csr_req_addr  = addr;
      csr_req_wdata = wdata;
      @(posedge clk);
      #1;
      csr_req_valid = 1'b0;
      check({tag, "_resp_lat"}, csr_resp_valid, 64'd1);
      rdata = csr_resp_rdata;
      ill   = csr_resp_illegal;
      chg   = pmp_chg_valid;
      @(posedge clk);
      #1;
      check({tag, "_chg_one_cycle"}, pmp_chg_valid, 64'd0);
   endtask

   initial begin
      logic [63:0] rd, held;
      logic        il, cg;

      csr_req_valid  = 1'b0;
      csr_req_op     = 2'd0;
      csr_req_addr   = 12'h0;
      csr_req_wdata  = 64'h0;
      csr_resp_ready = 1'b1;
      rstn           = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check_reset_outputs("reset");

      vecs.push_back('{2'd0, 12'h3A0, 64'h0,                  64'h0,                  1'b0, 1'b0});
      vecs.push_back('{2'd1, 12'h3A0, 64'h1F,                 64'h0,                  1'b0, 1'b1});
      vecs.push_back('{2'd0, 12'h3A0, 64'h0,                  64'h1F,                 1'b0, 1'b0});
      vecs.push_back('{2'd1, 12'h3A0, 64'h021F,               64'h1F,                 1'b0, 1'b0});
      vecs.push_back('{2'd0, 12'h3A0, 64'h0,                  64'h1F,                 1'b0, 1'b0});
      vecs.push_back('{2'd1, 12'h3A0, 64'h8F001F,             64'h1F,                 1'b0, 1'b1});
      vecs.push_back('{2'd1, 12'h3B1, 64'h1234,               64'h0,                  1'b0, !TOR_LOCK});
      vecs.push_back('{2'd0, 12'h3B1, 64'h0,   TOR_LOCK ? 64'h0 : 64'h1234,           1'b0, 1'b0});
      vecs.push_back('{2'd3, 12'h3A0, 64'hFF0000,             64'h8F001F,             1'b0, 1'b0});
      vecs.push_back('{2'd0, 12'h3A0, 64'h0,                  64'h8F001F,             1'b0, 1'b0});
      vecs.push_back('{2'd1, 12'h3A1, 64'hFFFF,               64'h0,                  1'b1, 1'b0});
      vecs.push_back('{2'd0, 12'h3C0, 64'h0,                  64'h0,                  1'b1, 1'b0});
      vecs.push_back('{2'd1, 12'h3A2, 64'h7F,                 64'h0,                  1'b0, 1'b1});
      vecs.push_back('{2'd0, 12'h3A2, 64'h0,                  64'h1F,                 1'b0, 1'b0});
      vecs.push_back('{2'd2, 12'h3A2, 64'h0300,               64'h1F,                 1'b0, 1'b1});
      vecs.push_back('{2'd1, 12'h3BF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                 1'b0, 1'b1});
      vecs.push_back('{2'd0, 12'h3BF, 64'h0,                  64'h003F_FFFF_FFFF_FFFF, 1'b0, 1'b0});
      vecs.push_back('{2'd1, 12'h3B2, 64'h55,                 64'h0,                  1'b0, 1'b0});
      vecs.push_back('{2'd0, 12'h3B2, 64'h0,                  64'h0,                  1'b0, 1'b0});
      vecs.push_back('{2'd1, 12'h3A0, 64'h0,                  64'h8F001F,             1'b0, 1'b1});
      vecs.push_back('{2'd0, 12'h3A0, 64'h0,                  64'h8F0000,             1'b0, 1'b0});
      vecs.push_back('{2'd1, 12'h3B0, 64'hABC,                64'h0,                  1'b0, 1'b1});
      vecs.push_back('{2'd3, 12'h3B0, 64'hC,                  64'hABC,                1'b0, 1'b1});
      vecs.push_back('{2'd0, 12'h3B0, 64'h0,                  64'hAB0,                1'b0, 1'b0});
      vecs.push_back('{2'd1, 12'h3A2, 64'h0398,               64'h031F,               1'b0, 1'b1});
      vecs.push_back('{2'd1, 12'h3A2, 64'h0,                  64'h0398,               1'b0, 1'b1});
      vecs.push_back('{2'd0, 12'h3A2, 64'h0,                  64'h98,                 1'b0, 1'b0});
      vecs.push_back('{2'd1, 12'h3B8, 64'h77,                 64'h0,                  1'b0, 1'b0});
      vecs.push_back('{2'd0, 12'h3B8, 64'h0,                  64'h0,                  1'b0, 1'b0});
      vecs.push_back('{2'd1, 12'h3B7, 64'h77,                 64'h0,                  1'b0, 1'b1});
      vecs.push_back('{2'd0, 12'h3B7, 64'h0,                  64'h77,                 1'b0, 1'b0});

      for (int i = 0; i < vecs.size(); i++) begin
         do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, $sformatf("v%0d", i), rd, il, cg);
         check($sformatf("v%0d_rdata", i),   rd, vecs[i].rdata);
         check($sformatf("v%0d_illegal", i), il, 64'(vecs[i].ill));
         check($sformatf("v%0d_chg", i),     cg, 64'(vecs[i].chg));
      end

      // configuration outputs after the table
      check("out_cfg_grp0",  pmpcfg[23:0],          64'h8F0000);
      check("out_cfg_grp1",  pmpcfg[79:64],         64'h0098);
      check("out_addr0",     pmpaddr[0 +: AW],      64'hAB0);
      check("out_addr1",     pmpaddr[AW +: AW],     TOR_LOCK ? 64'h0 : 64'h1234);
      check("out_addr7",     pmpaddr[7*AW +: AW],   64'h77);
      check("out_addr15",    pmpaddr[15*AW +: AW],  64'h003F_FFFF_FFFF_FFFF);

      // backpressure: response held, second request must wait and never land
      @(negedge clk);
      csr_resp_ready = 1'b0;
      csr_req_valid  = 1'b1;
      csr_req_op     = 2'd0;
      csr_req_addr   = 12'h3A0;
      csr_req_wdata  = 64'h0;
      @(posedge clk);
      #1;
      csr_req_op    = 2'd1;
      csr_req_addr  = 12'h3B5;
      csr_req_wdata = 64'h99;
      held = csr_resp_rdata;
      check("bp_first_rdata", held, 64'h8F0000);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp_c%0d_resp_valid", c), csr_resp_valid,   64'd1);
         check($sformatf("bp_c%0d_rdata", c),      csr_resp_rdata,   64'h8F0000);
         check($sformatf("bp_c%0d_illegal", c),    csr_resp_illegal, 64'd0);
         check($sformatf("bp_c%0d_req_ready", c),  csr_req_ready,    64'd0);
      end
      @(negedge clk);
      csr_req_valid  = 1'b0;
      csr_resp_ready = 1'b1;
      do_req(2'd0, 12'h3B5, 64'h0, "bp_after", rd, il, cg);
      check("bp_after_rdata", rd, 64'h0);

      // reset while a write response is pending
      @(negedge clk);
      csr_resp_ready = 1'b0;
      csr_req_valid  = 1'b1;
      csr_req_op     = 2'd1;
      csr_req_addr   = 12'h3A0;
      csr_req_wdata  = 64'h1F;
      @(posedge clk);
      #1;
      csr_req_valid = 1'b0;
      check("rst_pre_resp_valid", csr_resp_valid, 64'd1);
      check("rst_pre_rdata",      csr_resp_rdata, 64'h8F0000);
      check("rst_pre_cfg",        pmpcfg[23:0],   64'h8F001F);
      check("rst_pre_chg",        pmp_chg_valid,  64'd1);
      #2;
      rstn = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      @(negedge clk);
      rstn           = 1'b1;
      csr_resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("rst_release");
      do_req(2'd0, 12'h3A0, 64'h0, "rst_read", rd, il, cg);
      check("rst_read_rdata", rd, 64'h0);
      check("rst_read_chg",   cg, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
